// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined lookahead add/subtract unit.
// Latency: none; this file holds only constants and types.
// Backpressure: not applicable.
package cla_pkg;

    // Operation select as driven on in_sub
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Result flags, carried together from the final stage
    typedef struct packed {
        logic c;    // carry out of MSB (subtract: 1 = no borrow)
        logic v;    // signed overflow
        logic n;    // sign of result
        logic z;    // result is zero
    } flags_t;

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice: sum, carry out and carry into the top bit.
// Latency: combinational.
// Backpressure: none; pipeline registers and handshake live in the parent.
//
// Ports:
//   a, b      GROUP-bit operands (b already inverted for subtract)
//   cin       carry into bit 0 of the group
//   sum       GROUP-bit sum
//   cout      carry out of the top bit of the group
//   c_msb_in  carry into the top bit of the group (used for overflow)
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             acc_c;
    logic             run_p;

    // Every carry is a flat sum-of-products of generate/propagate terms and
    // cin, so carry depth does not grow bit by bit inside the group:
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c[0]  = cin;
        acc_c = 1'b0;
        run_p = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            acc_c = g[i];
            run_p = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc_c = acc_c | (run_p & g[j]);
                run_p = run_p & p[j];
            end
            c[i+1] = acc_c | (run_p & cin);
        end
    end

    assign sum      = p ^ c[GROUP-1:0];
    assign cout     = c[GROUP];
    assign c_msb_in = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined two's-complement add/subtract, one GROUP-bit lookahead group per stage, with C/V/N/Z flags.
// Latency: WIDTH/GROUP cycles from accept to out_valid; one beat per cycle when out_ready is high.
// Backpressure: whole pipe freezes while out_valid & !out_ready; in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             operand handshake; in_a, in_b operands, in_sub 0:A+B 1:A-B
//   out_valid/out_ready           result handshake; out_sum result
//   out_c, out_v, out_n, out_z    carry-out, signed overflow, negative, zero
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_v,
    output logic             out_n,
    output logic             out_z
);

    localparam int NSTG = WIDTH / GROUP;

    if ((GROUP < 1) || (GROUP > 8) || ((WIDTH % GROUP) != 0)) begin : g_bad_param
        $error("pipelined_cla_addsub: GROUP must be 1..8 and divide WIDTH");
    end

    logic             advance;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    flags_t           out_flg_q;

    // Inputs seen by stage k. Remaining operand bits are shifted down as
    // they travel, so every stage finds its group in the low GROUP bits.
    logic [WIDTH-1:0] src_a [NSTG];
    logic [WIDTH-1:0] src_b [NSTG];
    logic [WIDTH-1:0] src_s [NSTG];
    logic             src_c [NSTG];
    logic             src_v [NSTG];

    assign advance  = !out_valid_q | out_ready;
    assign in_ready = advance;

    assign src_a[0] = in_a;
    assign src_b[0] = in_b ^ {WIDTH{in_sub == OP_SUB}};
    assign src_c[0] = (in_sub == OP_SUB);
    assign src_s[0] = '0;
    assign src_v[0] = in_valid & advance;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [GROUP-1:0] g_sum;
        logic             g_cout;
        logic             g_cmsb;
        logic [WIDTH-1:0] s_d;

        cla_group #(.GROUP(GROUP)) u_grp (
            .a        (src_a[k][GROUP-1:0]),
            .b        (src_b[k][GROUP-1:0]),
            .cin      (src_c[k]),
            .sum      (g_sum),
            .cout     (g_cout),
            .c_msb_in (g_cmsb)
        );

        // Group bits of the partial sum are still zero here, so OR inserts them
        assign s_d = src_s[k] | (WIDTH'(g_sum) << (k * GROUP));

        if (k < NSTG - 1) begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;
            logic             v_q;

            // Valid shifts on every advance so bubbles move like beats;
            // data only loads with a real beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= src_v[k];
                    if (src_v[k]) begin
                        a_q <= src_a[k] >> GROUP;
                        b_q <= src_b[k] >> GROUP;
                        s_q <= s_d;
                        c_q <= g_cout;
                    end
                end
            end

            assign src_a[k+1] = a_q;
            assign src_b[k+1] = b_q;
            assign src_s[k+1] = s_q;
            assign src_c[k+1] = c_q;
            assign src_v[k+1] = v_q;
        end else begin : g_last
            // Final stage is the output register; flags come from the same beat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_sum_q   <= '0;
                    out_flg_q   <= '0;
                end else if (advance) begin
                    out_valid_q <= src_v[k];
                    if (src_v[k]) begin
                        out_sum_q <= s_d;
                        out_flg_q <= {g_cout, g_cmsb ^ g_cout, s_d[WIDTH-1], ~|s_d};
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_c     = out_flg_q.c;
    assign out_v     = out_flg_q.v;
    assign out_n     = out_flg_q.n;
    assign out_z     = out_flg_q.z;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: 16/4 main instance plus 8/8, 12/3, 32/4 parameter variants.
// Latency: expected WIDTH/GROUP cycles per instance.
// Backpressure: main instance sees random out_ready; variants are always ready.
module tb_pipelined_cla_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] sum;
        logic [3:0]  f;
        int          cyc;
    } exp_t;

    // ---------------- main instance (16/4) ----------------
    logic        in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_sum;
    logic        out_c, out_v, out_n, out_z;

    pipelined_cla_addsub #(.WIDTH(16), .GROUP(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_c(out_c), .out_v(out_v), .out_n(out_n), .out_z(out_z)
    );

    // ---------------- parameter variants ----------------
    logic        sv, ssub;
    logic [31:0] sa, sb;
    logic        r8, r12, r32, v8, v12, v32;
    logic [7:0]  s8;
    logic [11:0] s12;
    logic [31:0] s32;
    logic [3:0]  f8, f12, f32;

    pipelined_cla_addsub #(.WIDTH(8), .GROUP(8)) u_w8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sv), .in_ready(r8), .in_a(sa[7:0]), .in_b(sb[7:0]), .in_sub(ssub),
        .out_valid(v8), .out_ready(1'b1), .out_sum(s8),
        .out_c(f8[3]), .out_v(f8[2]), .out_n(f8[1]), .out_z(f8[0])
    );
    pipelined_cla_addsub #(.WIDTH(12), .GROUP(3)) u_w12 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sv), .in_ready(r12), .in_a(sa[11:0]), .in_b(sb[11:0]), .in_sub(ssub),
        .out_valid(v12), .out_ready(1'b1), .out_sum(s12),
        .out_c(f12[3]), .out_v(f12[2]), .out_n(f12[1]), .out_z(f12[0])
    );
    pipelined_cla_addsub #(.WIDTH(32), .GROUP(4)) u_w32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sv), .in_ready(r32), .in_a(sa), .in_b(sb), .in_sub(ssub),
        .out_valid(v32), .out_ready(1'b1), .out_sum(s32),
        .out_c(f32[3]), .out_v(f32[2]), .out_n(f32[1]), .out_z(f32[0])
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: flags from the sign rule, not from carries
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input int c);
        exp_t        e;
        logic [63:0] mask, aa, bb;
        logic [64:0] full;
        mask  = (64'd1 << w) - 64'd1;
        aa    = a & mask;
        bb    = (sub ? ~b : b) & mask;
        full  = {1'b0, aa} + {1'b0, bb} + 65'(sub);
        e.sum = full[63:0] & mask;
        e.f[3] = full[w];
        e.f[2] = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
        e.f[1] = e.sum[w-1];
        e.f[0] = (e.sum == 64'd0);
        e.cyc = c;
        return e;
    endfunction

    exp_t        q0[$], q8[$], q12[$], q32[$];
    exp_t        e0, e8, e12, e32;
    logic        stall_q;
    logic [20:0] hold;

    // Main scoreboard: push on accept, pop on output handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (in_valid && in_ready) q0.push_back(model(16, 64'(in_a), 64'(in_b), in_sub, cyc));
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (stall_q)
                check("stall_hold", 64'({out_valid, out_sum, out_c, out_v, out_n, out_z}), 64'(hold));
            if (out_valid && out_ready) begin
                if (q0.size() == 0) check("unexpected_out", 64'(out_valid), 64'(0));
                else begin
                    e0 = q0.pop_front();
                    check("sum", 64'(out_sum), e0.sum);
                    check("flags", 64'({out_c, out_v, out_n, out_z}), 64'(e0.f));
                end
            end
            stall_q <= out_valid && !out_ready;
            hold    <= {out_valid, out_sum, out_c, out_v, out_n, out_z};
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (sv && r8) q8.push_back(model(8, 64'(sa), 64'(sb), ssub, cyc));
            if (v8) begin
                if (q8.size() == 0) check("w8_unexpected", 64'(v8), 64'(0));
                else begin
                    e8 = q8.pop_front();
                    check("w8_sum", 64'(s8), e8.sum);
                    check("w8_flags", 64'(f8), 64'(e8.f));
                    check("w8_lat", 64'(cyc - e8.cyc), 64'(1));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (sv && r12) q12.push_back(model(12, 64'(sa), 64'(sb), ssub, cyc));
            if (v12) begin
                if (q12.size() == 0) check("w12_unexpected", 64'(v12), 64'(0));
                else begin
                    e12 = q12.pop_front();
                    check("w12_sum", 64'(s12), e12.sum);
                    check("w12_flags", 64'(f12), 64'(e12.f));
                    check("w12_lat", 64'(cyc - e12.cyc), 64'(4));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (sv && r32) q32.push_back(model(32, 64'(sa), 64'(sb), ssub, cyc));
            if (v32) begin
                if (q32.size() == 0) check("w32_unexpected", 64'(v32), 64'(0));
                else begin
                    e32 = q32.pop_front();
                    check("w32_sum", 64'(s32), e32.sum);
                    check("w32_flags", 64'(f32), 64'(e32.f));
                    check("w32_lat", 64'(cyc - e32.cyc), 64'(8));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic rnd_rdy = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub, output int acyc);
        logic ok;
        ok       = 1'b0;
        acyc     = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok   = in_ready;
            acyc = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accept", 64'(ok), 64'(1));
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic [15:0] es, input logic [3:0] ef);
        int acyc;
        int n;
        send(a, b, sub, acyc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_lat"}, 64'(cyc - acyc), 64'(4));
        check({tag, "_sum"}, 64'(out_sum), 64'(es));
        check({tag, "_flags"}, 64'({out_c, out_v, out_n, out_z}), 64'(ef));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && q0.size() != 0; n++) @(negedge clk);
        check("drain", 64'(q0.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ac;
        rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        sv = 1'b0; ssub = 1'b0; sa = '0; sb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(out_sum), 64'(0));
        check("rst_flags", 64'({out_c, out_v, out_n, out_z}), 64'(0));
        check("rst_w8", 64'({v8, s8, f8}), 64'(0));
        check("rst_w32", 64'({v32, s32, f32}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner cases; flags are {C,V,N,Z}
        directed("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0110);
        directed("wrap_add", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1001);
        directed("borrow",   16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b0010);
        directed("ovf_sub",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1100);

        // Random back-to-back beats under random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 100; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), ac);
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) send(16'(1000 * i + 77), 16'h1234, 1'b0, ac);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_sum", 64'(out_sum), 64'(0));
        check("midrst_flags", 64'({out_c, out_v, out_n, out_z}), 64'(0));
        q0.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        directed("post_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 4'b0000);

        // Parameter variants: every 8-bit A, half of B per op, random upper bits
        sv = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int j = 0; j < 128; j++) begin
                sa       = $urandom;
                sb       = $urandom;
                sa[7:0]  = 8'(a);
                sb[7:0]  = 8'(2 * j + ((a ^ j) & 1));
                ssub     = 1'(j & 1);
                @(posedge clk);
                #1;
            end
        end
        sv = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("w8_drain", 64'(q8.size()), 64'(0));
        check("w12_drain", 64'(q12.size()), 64'(0));
        check("w32_drain", 64'(q32.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
